data_ram_arbiter: RTL and testbench
===================================

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18, address width of the data RAM.
REQ-002 SHALL have parameter WORD_SIZE, default 18, data word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive cycles port B waits while A wins; range 1..15.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req/a_we  input  1 each  port A (processor) access request / write strobe.
REQ-007 SHALL have ports a_addr  input  ADDR_SIZE and a_din  input  WORD_SIZE  port A address and write data.
REQ-008 SHALL have ports a_gnt  output  1, a_rvalid  output  1, a_rdata  output  WORD_SIZE  port A grant, read-data valid, read data.
REQ-009 SHALL have ports b_req, b_we, b_addr, b_din, b_gnt, b_rvalid, b_rdata for port B (loader/debug), with widths identical to port A.
REQ-010 SHALL have ports ram_we  output  1, ram_addr  output  ADDR_SIZE, ram_din  output  WORD_SIZE, ram_dout  input  WORD_SIZE, wired to the single-port data RAM.

Function
REQ-011 SHALL grant at most one port per cycle; a_gnt and b_gnt are combinational from requests and internal state, never both high.
REQ-012 SHALL complete an access in the cycle its grant is high: ram_addr/ram_din/ram_we driven from the granted port; ram_we = granted port's we.
REQ-013 SHALL hold ram_we low and ram_addr/ram_din at 0 when no port is granted.
REQ-014 SHALL treat the RAM read as one-cycle latency: granted read (we=0) in cycle N yields x_rvalid high for exactly cycle N+1 with x_rdata = ram_dout.
REQ-015 SHALL drive x_rdata to 0 whenever x_rvalid is low.
REQ-016 SHALL never assert rvalid for a granted write.
REQ-017 SHALL keep a two-bit state LAST in {IDLE, A, B} recording the previous cycle's grant; LAST selects which rvalid fires.
REQ-018 SHALL, with only one port requesting, grant that port.
REQ-019 SHALL, with both requesting, grant A unless the starvation rule (REQ-026) forces B.
REQ-020 SHALL allow back-to-back grants to the same port every cycle; pipelined reads return in request order.
REQ-021 SHALL allow a requester to drop req in the cycle after grant without penalty; a request not granted requires req, we, addr, din held stable until granted.
REQ-022 SHALL, on simultaneous B write and A read to the same address with A granted, return the pre-write value to A; B's write occurs in its later grant cycle.

Reset
REQ-023 SHALL, while reset is low, force a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we to 0, rdata and ram_addr/ram_din to 0, LAST to IDLE, starvation counter to 0.
REQ-024 SHALL, on reset asserted mid-read, suppress the pending rvalid; no rvalid appears after reset release for pre-reset grants.
REQ-025 SHALL evaluate requests normally in the first rising edge cycle after reset deassertion.

Configuration
REQ-026 SHALL, when macro DATA_ARB_STARVE_LIMIT_EN is defined, count consecutive cycles where b_req is high and b_gnt is low; when count equals STARVE_LIMIT, grant B that cycle regardless of a_req and clear the counter; counter clears on any B grant or b_req low.
REQ-027 SHALL, when DATA_ARB_STARVE_LIMIT_EN is undefined, use strict priority A over B, omit the counter logic, and ignore STARVE_LIMIT.

Verification
REQ-028 SHALL cover: A read addr 5 (mem[5]=0x12345) alone -> a_gnt same cycle, a_rvalid next cycle, a_rdata=0x12345, b_rvalid 0.
REQ-029 SHALL cover: A and B both request continuously, macro undefined -> a_gnt every cycle for 20 cycles, b_gnt never.
REQ-030 SHALL cover: same stimulus, macro defined, STARVE_LIMIT=4 -> b_gnt in cycles 5, 10, 15, 20; A granted all other cycles.
REQ-031 SHALL cover: B writes 0x3FFFF to addr 7 then A reads addr 7 next cycle -> a_rdata=0x3FFFF, ram_we high only in the B cycle.
REQ-032 SHALL cover: A read granted then reset pulsed low before next edge -> a_rvalid stays 0, all outputs 0 during reset.
REQ-033 SHALL cover: alternating A read addr 1 / B read addr 2 back-to-back -> rvalids alternate, each with correct data, never both high.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//
// Purpose:
//   Arbitrates two requesters (port A = processor, port B = loader/debug) onto
//   one single-port synchronous data RAM. At most one port is granted per cycle
//   and the access completes in its grant cycle. Reads have one cycle of
//   latency. Read data comes back on the port that was granted in the
//   previous cycle.
//
// Handshake (both ports):
//   A port raises x_req together with x_we/x_addr/x_din. The grant x_gnt is
//   combinational in the same cycle. The access is taken on the rising edge
//   that ends a cycle in which x_gnt is high.
//   While x_req is high and x_gnt is low, the requester holds x_we, x_addr and
//   x_din stable. The requester may drop x_req in the cycle after a grant.
//   A granted read returns x_rvalid high for exactly the next cycle, with
//   x_rdata = ram_dout. x_rdata is 0 whenever x_rvalid is low.
//   A granted write never produces x_rvalid.
//
// Arbitration:
//   When both ports request, port A wins.
//   When DATA_ARB_STARVE_LIMIT_EN is defined, a counter tracks how many
//   consecutive cycles B has waited. When the count reaches STARVE_LIMIT, B is
//   granted that cycle regardless of A. The counter clears on a B grant or
//   when b_req is low.
//   When DATA_ARB_STARVE_LIMIT_EN is undefined, the counter is absent and A
//   has strict priority.
//
// Ports:
//   clock                    sole clock, rising edge
//   reset                    asynchronous, active-low reset
//   a_req/a_we/a_addr/a_din  port A request, write strobe, address, write data
//   a_gnt/a_rvalid/a_rdata   port A grant, read-data valid, read data
//   b_*                      port B, same meaning and widths as port A
//   ram_we/ram_addr/ram_din  RAM write strobe, address and write data
//   ram_dout                 RAM read data, one cycle after the address
//   dbg_last                 current LAST state (0 = IDLE, 1 = A, 2 = B)
//
// Configuration macro: DATA_ARB_STARVE_LIMIT_EN
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
  parameter int ADDR_SIZE    = 18,
  parameter int WORD_SIZE    = 18,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  // port A
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_din,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WORD_SIZE-1:0] a_rdata,
  // port B
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_din,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WORD_SIZE-1:0] b_rdata,
  // RAM side
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  input  logic [WORD_SIZE-1:0] ram_dout,
  // observability
  output logic [1:0]           dbg_last
);

  // Elaboration-time check of the starvation limit range.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("data_ram_arbiter: STARVE_LIMIT must lie in 1..15");
  end

  typedef enum logic [1:0] {
    LAST_IDLE = 2'd0,
    LAST_A    = 2'd1,
    LAST_B    = 2'd2
  } last_t;

  last_t last;      // grant of the previous cycle
  logic  last_rd;   // that grant was a read (so its data is due this cycle)
  logic  force_b;   // starvation rule overrides A's priority this cycle

  // ---------------------------------------------------------------------------
  // Starvation counter (optional)
  // ---------------------------------------------------------------------------
`ifdef DATA_ARB_STARVE_LIMIT_EN
  logic [3:0] starve_cnt;

  // starve_cnt holds the number of cycles B has already waited.
  // B is forced through on the cycle in which that count hits the limit.
  assign force_b = b_req && (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (!b_req || b_gnt) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grants
  // ---------------------------------------------------------------------------
  // The reset term keeps both grants low while reset is held. It acts
  // asynchronously on the combinational path, exactly like the registers.
  assign b_gnt = reset && b_req && (!a_req || force_b);
  assign a_gnt = reset && a_req && !b_gnt;

  // ---------------------------------------------------------------------------
  // RAM request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_din;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_din;
    end
  end

  // ---------------------------------------------------------------------------
  // LAST state: remembers who owned the RAM in the previous cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last    <= LAST_IDLE;
      last_rd <= 1'b0;
    end else if (a_gnt) begin
      last    <= LAST_A;
      last_rd <= !a_we;
    end else if (b_gnt) begin
      last    <= LAST_B;
      last_rd <= !b_we;
    end else begin
      last    <= LAST_IDLE;
      last_rd <= 1'b0;
    end
  end

  assign dbg_last = last;

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // A reset clears last/last_rd asynchronously. Any read that was in flight
  // across a reset therefore never produces rvalid.
  assign a_rvalid = (last == LAST_A) && last_rd;
  assign b_rvalid = (last == LAST_B) && last_rd;
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_ram_arbiter
//
// Purpose:
//   Self-checking bench for data_ram_arbiter with default parameters.
//   A 64-word synchronous RAM model sits on the RAM side; it can be preloaded
//   through a backdoor port while reset is held.
//
//   The reference model works at transaction level:
//     - expected grant = priority rule plus a waiting-cycle count for B;
//     - a shadow memory (ref_mem) is updated by each expected write;
//     - exp_q holds {port, data} of each granted read, checked one cycle later.
//
//   Build with +define+DATA_ARB_STARVE_LIMIT_EN to check the starvation build.
// -----------------------------------------------------------------------------
module tb_data_ram_arbiter;

  localparam int AW    = 18;
  localparam int W     = 18;
  localparam int LIMIT = 4;
`ifdef DATA_ARB_STARVE_LIMIT_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_din = '0, b_din = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [W-1:0]  a_rdata, b_rdata, ram_din;
  logic [W-1:0]  ram_dout;
  logic [AW-1:0] ram_addr;
  logic [1:0]    dbg_last;

  data_ram_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(W), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clk), .reset(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .dbg_last(dbg_last)
  );

  // ---------------------------------------------------------------------------
  // RAM model (read-before-write, one-cycle read latency) with backdoor load
  // ---------------------------------------------------------------------------
  logic         bd_we = 1'b0;
  logic [5:0]   bd_addr = '0;
  logic [W-1:0] bd_data = '0;
  logic [W-1:0] mem [0:63];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr[5:0]] <= ram_din;
    ram_dout <= mem[ram_addr[5:0]];
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] ref_mem [0:63];
  logic [W:0]   exp_q[$];            // {is_port_b, data}
  int           wait_cnt = 0;        // cycles B has waited so far
  logic         last_a = 0, last_b = 0;
  logic         dut_b_gnt_seen = 0;
  int           total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_gnt"},    a_gnt,    0);
    chk({tag, "_b_gnt"},    b_gnt,    0);
    chk({tag, "_a_rvalid"}, a_rvalid, 0);
    chk({tag, "_b_rvalid"}, b_rvalid, 0);
    chk({tag, "_a_rdata"},  a_rdata,  0);
    chk({tag, "_b_rdata"},  b_rdata,  0);
    chk({tag, "_ram_we"},   ram_we,   0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"},  ram_din,  0);
  endtask

  // One clock cycle: inputs are already set (1 time unit after the rising
  // edge). Outputs are checked at the falling edge, then the model advances.
  task automatic cycle();
    logic         exp_a, exp_b, exp_arv, exp_brv, exp_we;
    logic [W-1:0] exp_ard, exp_brd, exp_din;
    logic [AW-1:0] exp_addr;
    logic [W:0]   e;
    @(negedge clk);
    exp_b = b_req && (!a_req || (STARVE_EN && wait_cnt == LIMIT));
    exp_a = a_req && !exp_b;
    exp_we = exp_a ? a_we : (exp_b ? b_we : 1'b0);
    exp_addr = exp_a ? a_addr : (exp_b ? b_addr : '0);
    exp_din  = exp_a ? a_din : (exp_b ? b_din : '0);
    exp_arv = 0; exp_brv = 0; exp_ard = '0; exp_brd = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[W]) begin exp_brv = 1; exp_brd = e[W-1:0]; end
      else begin exp_arv = 1; exp_ard = e[W-1:0]; end
    end
    chk("a_gnt", a_gnt, exp_a);
    chk("b_gnt", b_gnt, exp_b);
    chk("ram_we", ram_we, exp_we);
    chk("ram_addr", ram_addr, exp_addr);
    chk("ram_din", ram_din, exp_din);
    chk("a_rvalid", a_rvalid, exp_arv);
    chk("a_rdata", a_rdata, exp_ard);
    chk("b_rvalid", b_rvalid, exp_brv);
    chk("b_rdata", b_rdata, exp_brd);
    chk("rvalid_excl", a_rvalid & b_rvalid, 0);
    dut_b_gnt_seen = b_gnt;
    last_a = exp_a;
    last_b = exp_b;
    if (exp_a) begin
      if (a_we) ref_mem[a_addr[5:0]] = a_din;
      else exp_q.push_back({1'b0, ref_mem[a_addr[5:0]]});
    end else if (exp_b) begin
      if (b_we) ref_mem[b_addr[5:0]] = b_din;
      else exp_q.push_back({1'b1, ref_mem[b_addr[5:0]]});
    end
    wait_cnt = (b_req && !exp_b) ? wait_cnt + 1 : 0;
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input int addr, input logic [W-1:0] din);
    a_req = req; a_we = we; a_addr = AW'(addr); a_din = din;
  endtask

  task automatic drive_b(input logic req, input logic we, input int addr, input logic [W-1:0] din);
    b_req = req; b_we = we; b_addr = AW'(addr); b_din = din;
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] mask, exp_mask;

    // Reset and RAM preload. Outputs are checked while reset is held.
    #2;
    chk_all_zero("reset");
    for (int i = 0; i < 64; i++) begin
      bd_addr = 6'(i);
      bd_data = (i == 5) ? 18'h12345 : W'($urandom_range(0, 18'h3FFFF));
      ref_mem[i] = bd_data;
      bd_we = 1'b1;
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
    chk_all_zero("reset_hold");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single A read of address 5.
    drive_a(1, 0, 5, '0);
    cycle();
    drive_a(0, 0, 0, '0);
    cycle();
    cycle();

    // B writes 0x3FFFF to address 7, then A reads address 7.
    drive_b(1, 1, 7, 18'h3FFFF);
    cycle();
    drive_b(0, 0, 0, '0);
    drive_a(1, 0, 7, '0);
    cycle();
    drive_a(0, 0, 0, '0);
    cycle();

    // Both ports request continuously for 20 cycles.
    mask = '0;
    exp_mask = '0;
    drive_a(1, 0, 3, '0);
    drive_b(1, 0, 2, '0);
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (dut_b_gnt_seen) mask[i] = 1'b1;
      if (STARVE_EN && (i % (LIMIT + 1)) == 0) exp_mask[i] = 1'b1;
    end
    chk("contention_b_gnt_pattern", mask, exp_mask);
    drive_a(0, 0, 0, '0);
    drive_b(0, 0, 0, '0);
    cycle();
    cycle();

    // Alternating A read of address 1 and B read of address 2.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin drive_a(1, 0, 1, '0); drive_b(0, 0, 0, '0); end
      else            begin drive_a(0, 0, 0, '0); drive_b(1, 0, 2, '0); end
      cycle();
    end
    drive_a(0, 0, 0, '0);
    drive_b(0, 0, 0, '0);
    cycle();

    // Same-address collision: A reads address 9 while B writes it.
    // A is granted and sees the old value; B's write lands in its own grant.
    drive_a(1, 0, 9, '0);
    drive_b(1, 1, 9, 18'h0ABCD);
    cycle();
    drive_a(0, 0, 0, '0);
    cycle();
    drive_b(0, 0, 0, '0);
    drive_a(1, 0, 9, '0);
    cycle();
    drive_a(0, 0, 0, '0);
    cycle();

    // Reset pulsed while an A read is in flight.
    drive_a(1, 0, 5, '0);
    @(negedge clk);
    chk("pre_reset_a_gnt", a_gnt, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(posedge clk); #1;
    chk_all_zero("mid_reset_edge");
    drive_a(0, 0, 0, '0);
    exp_q.delete();
    wait_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();
    cycle();

    // Randomized traffic. A port that was not granted keeps its request.
    last_a = 0; last_b = 0;
    for (int i = 0; i < 300; i++) begin
      if (!(a_req && !last_a))
        drive_a($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 63),
                W'($urandom_range(0, 18'h3FFFF)));
      if (!(b_req && !last_b))
        drive_b($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 63),
                W'($urandom_range(0, 18'h3FFFF)));
      cycle();
    end
    drive_a(0, 0, 0, '0);
    drive_b(0, 0, 0, '0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
